// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - M-stage data-memory access FSM and MEM/WB pipeline register
//
// Purpose: runs the load/store of the instruction in M over a req/ack bus with
// variable latency, stalls the upstream stages while the access is pending,
// and holds the MEM/WB register feeding writeback.
//
// Ports:
//   clk, reset                 pipeline clock, synchronous active-high reset
//   aluoutM, writedataM        effective address / ALU result, store data
//   writeregM                  destination register
//   regwriteM, memtoregM,      M-stage controls (memtoregM = load)
//   memwriteM
//   stallM                     freeze PC, IF/ID, ID/EX, EX/MEM
//   mem_req, mem_we,           registered bus request, write strobe,
//   mem_addr, mem_wdata        address and store data (held while pending)
//   mem_ack, mem_rdata         completion pulse and load data
//   regwriteW, memtoregW,      W-stage controls and data
//   aluoutW, readdataW,
//   writeregW, buserrW         buserrW: the access now in W failed
//
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned accesses fail
// without touching the bus).

module mem_wb_stage #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   aluoutM,
  input  logic [31:0]   writedataM,
  input  logic [4:0]    writeregM,
  input  logic          regwriteM,
  input  logic          memtoregM,
  input  logic          memwriteM,
  output logic          stallM,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic          regwriteW,
  output logic          memtoregW,
  output logic [31:0]   aluoutW,
  output logic [31:0]   readdataW,
  output logic [4:0]    writeregW,
  output logic          buserrW
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Counter only has to reach TIMEOUT-1; a disabled timeout lets it wrap.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          regwrite_w_q, regwrite_w_d;
  logic          memtoreg_w_q, memtoreg_w_d;
  logic [31:0]   aluout_w_q, aluout_w_d;
  logic [31:0]   readdata_w_q, readdata_w_d;
  logic [4:0]    writereg_w_q, writereg_w_d;
  logic          buserr_w_q, buserr_w_d;

  logic access;
  logic is_load;
  logic misaligned;
  logic stall;

  assign access  = memwriteM | memtoregM;
  // Store wins when both strobes are set.
  assign is_load = memtoregM & ~memwriteM;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = |aluoutM[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    readdata_w_d = readdata_w_q;
    stall        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (access) begin
          stall = 1'b1;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = memwriteM;
            addr_d  = AW'(aluoutM);
            wdata_d = writedataM;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        // Ack is checked first so a same-cycle ack beats the timeout.
        if (mem_ack) begin
          if (is_load) readdata_w_d = mem_rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // W register: bubble while stalled, otherwise take the M fields.
    if (stall) begin
      regwrite_w_d = 1'b0;
      memtoreg_w_d = 1'b0;
      buserr_w_d   = 1'b0;
      aluout_w_d   = aluout_w_q;
      writereg_w_d = writereg_w_q;
    end else begin
      regwrite_w_d = regwriteM & ~err_q;
      memtoreg_w_d = is_load;
      buserr_w_d   = err_q;
      aluout_w_d   = aluoutM;
      writereg_w_d = writeregM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      regwrite_w_q <= 1'b0;
      memtoreg_w_q <= 1'b0;
      aluout_w_q   <= '0;
      readdata_w_q <= '0;
      writereg_w_q <= '0;
      buserr_w_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      regwrite_w_q <= regwrite_w_d;
      memtoreg_w_q <= memtoreg_w_d;
      aluout_w_q   <= aluout_w_d;
      readdata_w_q <= readdata_w_d;
      writereg_w_q <= writereg_w_d;
      buserr_w_q   <= buserr_w_d;
    end
  end

  // Stall is masked during reset so the frozen stages see a clean pipeline.
  assign stallM    = stall & ~reset;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign regwriteW = regwrite_w_q;
  assign memtoregW = memtoreg_w_q;
  assign aluoutW   = aluout_w_q;
  assign readdataW = readdata_w_q;
  assign writeregW = writereg_w_q;
  assign buserrW   = buserr_w_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage

module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] aluoutM, writedataM;
  logic [4:0]  writeregM;
  logic        regwriteM, memtoregM, memwriteM;
  logic        stallM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        regwriteW, memtoregW;
  logic [31:0] aluoutW, readdataW;
  logic [4:0]  writeregW;
  logic        buserrW;

  int total    = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.AW(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .aluoutM(aluoutM), .writedataM(writedataM), .writeregM(writeregM),
    .regwriteM(regwriteM), .memtoregM(memtoregM), .memwriteM(memwriteM),
    .stallM(stallM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .regwriteW(regwriteW), .memtoregW(memtoregW), .aluoutW(aluoutW),
    .readdataW(readdataW), .writeregW(writeregW), .buserrW(buserrW)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; inputs are then driven and outputs sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] wr,
                       input logic rw, input logic mtr, input logic mw);
    aluoutM = a; writedataM = wd; writeregM = wr;
    regwriteM = rw; memtoregM = mtr; memwriteM = mw;
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick();

    // Reset state
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_stall", 32'(stallM), 32'h0);
    chk("rst_regwriteW", 32'(regwriteW), 32'h0);
    chk("rst_aluoutW", aluoutW, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);

    // ALU op, no access
    reset = 1'b0;
    drive(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("alu_stall", 32'(stallM), 32'h0);
    tick();
    chk("alu_aluoutW", aluoutW, 32'h10);
    chk("alu_writeregW", 32'(writeregW), 32'd5);
    chk("alu_regwriteW", 32'(regwriteW), 32'h1);
    chk("alu_buserrW", 32'(buserrW), 32'h0);

    // Load, ack after 2 BUSY cycles
    drive(32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
    chk("ld_stall_idle", 32'(stallM), 32'h1);
    tick();
    chk("ld_req_b1", 32'(mem_req), 32'h1);
    chk("ld_we", 32'(mem_we), 32'h0);
    chk("ld_addr", mem_addr, 32'h100);
    chk("ld_stall_b1", 32'(stallM), 32'h1);
    chk("ld_bubble_regwriteW", 32'(regwriteW), 32'h0);
    chk("ld_hold_aluoutW", aluoutW, 32'h10);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    chk("ld_req_b2", 32'(mem_req), 32'h1);
    chk("ld_stall_b2", 32'(stallM), 32'h1);
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("ld_req_done", 32'(mem_req), 32'h0);
    chk("ld_stall_done", 32'(stallM), 32'h0);
    chk("ld_readdataW", readdataW, 32'hDEADBEEF);
    tick();
    chk("ld_regwriteW", 32'(regwriteW), 32'h1);
    chk("ld_memtoregW", 32'(memtoregW), 32'h1);
    chk("ld_aluoutW", aluoutW, 32'h100);
    chk("ld_writeregW", 32'(writeregW), 32'd7);

    // Store with memtoregM also high, immediate ack; readdataW must not change
    drive(32'h200, 32'hCAFEF00D, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("st_stall_idle", 32'(stallM), 32'h1);
    tick();
    chk("st_we", 32'(mem_we), 32'h1);
    chk("st_wdata", mem_wdata, 32'hCAFEF00D);
    chk("st_addr", mem_addr, 32'h200);
    chk("st_memtoregW_busy", 32'(memtoregW), 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h12345678; #1;
    tick();
    mem_ack = 1'b0;
    chk("st_req_done", 32'(mem_req), 32'h0);
    chk("st_readdataW_hold", readdataW, 32'hDEADBEEF);
    tick();
    chk("st_memtoregW", 32'(memtoregW), 32'h0);
    chk("st_regwriteW", 32'(regwriteW), 32'h0);
    chk("st_aluoutW", aluoutW, 32'h200);

    // Timeout (TIMEOUT=4) on a load, no ack
    drive(32'h300, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("to_req_b%0d", i), 32'(mem_req), 32'h1);
    end
    tick();
    chk("to_req_done", 32'(mem_req), 32'h0);
    chk("to_stall_done", 32'(stallM), 32'h0);
    tick();
    chk("to_buserrW", 32'(buserrW), 32'h1);
    chk("to_regwriteW", 32'(regwriteW), 32'h0);
    chk("to_aluoutW", aluoutW, 32'h300);
    drive(32'h44, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("to_idle_stall", 32'(stallM), 32'h0);
    tick();
    chk("to_next_buserrW", 32'(buserrW), 32'h0);
    chk("to_next_regwriteW", 32'(regwriteW), 32'h1);

    // Ack in the same cycle the timeout would fire: ack wins
    drive(32'h500, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0);
    tick(); tick(); tick(); tick();
    mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5; #1;
    tick();
    mem_ack = 1'b0;
    chk("race_readdataW", readdataW, 32'hA5A5A5A5);
    tick();
    chk("race_buserrW", 32'(buserrW), 32'h0);
    chk("race_regwriteW", 32'(regwriteW), 32'h1);

    // Reset during the 2nd BUSY cycle
    drive(32'h400, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("rb_mem_req", 32'(mem_req), 32'h0);
    chk("rb_aluoutW", aluoutW, 32'h0);
    chk("rb_readdataW", readdataW, 32'h0);
    chk("rb_writeregW", 32'(writeregW), 32'h0);
    chk("rb_regwriteW", 32'(regwriteW), 32'h0);
    reset = 1'b0;
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'h77777777; #1;
    tick();
    mem_ack = 1'b0;
    chk("rb_late_ack_readdataW", readdataW, 32'h0);
    chk("rb_late_ack_req", 32'(mem_req), 32'h0);

    // Misaligned load at 0x102
    drive(32'h102, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
    chk("mis_stall_idle", 32'(stallM), 32'h1);
    tick();
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_req", 32'(mem_req), 32'h0);
    chk("mis_stall_done", 32'(stallM), 32'h0);
    tick();
    chk("mis_buserrW", 32'(buserrW), 32'h1);
    chk("mis_regwriteW", 32'(regwriteW), 32'h0);
`else
    chk("mis_req", 32'(mem_req), 32'h1);
    chk("mis_addr", mem_addr, 32'h102);
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D; #1;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("mis_readdataW", readdataW, 32'h0BADF00D);
    chk("mis_buserrW", 32'(buserrW), 32'h0);
    chk("mis_regwriteW", 32'(regwriteW), 32'h1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
